out_display_driver: RTL and testbench
=====================================

Name: out_display_driver

Overview:
- Downstream consumer of the CPU's 8-bit output register: converts the value to decimal and drives a 4-digit, common-anode, multiplexed 7-segment display.
- Sequential binary-to-BCD conversion uses double-dabble, one shift per clock.
- Time-multiplexed digit scan with leading-zero blanking.
- Sits between the CPU `out` port and board pins.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit stays active before the scan advances. Legal range 2..65535; counter is 16 bits.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- value  input  8  CPU output register value
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit)
- an  output  4  digit anodes, active-low; an[0] = ones, an[3] = leftmost
- busy  output  1  high while a conversion is in progress
- bcd  output  12  committed BCD {hundreds,tens,ones}, for debug/verification

Behaviour:
- Reset (async, reset_n=0), all registers cleared:
  - value_q=0, last_conv=0, shift register=0, bcd=12'h000, state=IDLE, digit index=0, refresh counter=0.
  - Outputs: an=4'b1110, seg=7'b1000000 ('0'), busy=0.
- Input stage: value_q <= value every cycle (1-cycle register).
- FSM states IDLE, SHIFT, DONE:
  - IDLE: if value_q != last_conv, load the 20-bit work register {12'h000, value_q}, cap <= value_q, iteration count <= 0, go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, add 3 to every BCD nibble >= 5, then shift the 20-bit register left by 1. After the 8th shift, go to DONE.
  - DONE: bcd <= work[19:8], last_conv <= cap, go to IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- Latency: value changes before edge 1 → value_q at edge 1 → SHIFT entered at edge 2 → 8 shifts (edges 3–10) → bcd committed at edge 11.
- value changing during SHIFT/DONE: ignored by the in-flight conversion. Re-detected in IDLE; the last stable value always ends displayed.
- Width: 8-bit input gives max 255, so the hundreds nibble is <= 2. No overflow is possible.
- Scan counter:
  - Counts 0..REFRESH_DIV-1.
  - On terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- an and seg are registered, recomputed every cycle from the digit index and bcd:
  - Index 0: ones digit, always shown.
  - Index 1: tens digit; blank (7'b1111111) if hundreds=0 and tens=0.
  - Index 2: hundreds digit; blank if hundreds=0.
  - Index 3: blank (see optional feature).
- Segment codes 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- Exactly one an bit is low at any time after reset.
- Reset mid-conversion: the conversion is aborted immediately and all state returns to reset values.

Optional Feature:
- Macro: SIGNED_DISPLAY_EN
- Defined:
  - value_q is treated as two's complement. The magnitude (0..128) is converted; -128 yields 12'h128.
  - A registered neg flag is committed with bcd in DONE.
  - Digit 3 shows '-' (7'b0111111) when neg=1, blank otherwise.
  - bcd holds the magnitude.
- Undefined: value is unsigned 0..255; digit 3 always blank. No neg logic is present.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle → an=4'b1110, seg=7'b1000000, busy=0, bcd=12'h000 immediately.
- value 0→173 (REFRESH_DIV=4):
  - busy rises after edge 2 and falls after edge 11; bcd=12'h173.
  - Scan shows seg 1111000 (7), 0110000 (3), 1111001 (1), blank.
  - an cycles 1110→1101→1011→0111→1110, 4 cycles each.
- value=5: bcd=12'h005; ones=0010010; tens and hundreds seg=7'b1111111; no spurious lit segments.
- value=200, then value=9 applied 3 cycles after busy rises: bcd=12'h200 first, then busy reasserts and bcd ends at 12'h009 with busy=0.
- value=255, then reset_n pulsed low during SHIFT: before the pulse, bcd=12'h255 after 11 edges; after the pulse, bcd=0 and busy=0, then re-conversion of 255 completes 11 edges after release.
- SIGNED_DISPLAY_EN defined:
  - value=8'hFF → bcd=12'h001, digit 3=7'b0111111.
  - 8'h80 → bcd=12'h128 with '-'.
  - 8'h7F → bcd=12'h127, digit 3 blank.

Source files
------------

// File: rtl/out_display_driver.sv
// rtl/out_display_driver.sv - 8-bit value to 4-digit multiplexed 7-segment display (double-dabble BCD)
// Optional macro SIGNED_DISPLAY_EN: two's-complement input, magnitude shown with '-' on digit 3.
module out_display_driver #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        busy,
  output logic [11:0] bcd
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [15:0] TERM  = 16'(REFRESH_DIV - 1);
  localparam logic [6:0]  BLANK = 7'b1111111;

  state_t      state;
  logic [7:0]  value_q;
  logic [7:0]  last_conv;
  logic [7:0]  cap;
  logic [19:0] work;
  logic [2:0]  iter;
  logic [15:0] refresh_cnt;
  logic [1:0]  digit_idx;
  logic [7:0]  load_val;
  logic [19:0] work_adj;
  logic [19:0] work_next;
  logic [6:0]  seg_next;
  logic [3:0]  an_next;

`ifdef SIGNED_DISPLAY_EN
  logic neg;
  // Negating 8'h80 wraps back to 8'h80, which read unsigned is the wanted 128.
  assign load_val = value_q[7] ? (~value_q + 8'd1) : value_q;
`else
  assign load_val = value_q;
`endif

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = BLANK;
    endcase
  endfunction

  // One double-dabble step: correct each BCD nibble, then shift.
  always_comb begin
    work_adj = work;
    if (work_adj[11:8]  >= 4'd5) work_adj[11:8]  = work_adj[11:8]  + 4'd3;
    if (work_adj[15:12] >= 4'd5) work_adj[15:12] = work_adj[15:12] + 4'd3;
    if (work_adj[19:16] >= 4'd5) work_adj[19:16] = work_adj[19:16] + 4'd3;
    work_next = {work_adj[18:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q   <= 8'h00;
      last_conv <= 8'h00;
      cap       <= 8'h00;
      work      <= 20'h00000;
      iter      <= 3'd0;
      bcd       <= 12'h000;
      busy      <= 1'b0;
      state     <= IDLE;
`ifdef SIGNED_DISPLAY_EN
      neg       <= 1'b0;
`endif
    end else begin
      value_q <= value;
      case (state)
        IDLE: begin
          if (value_q != last_conv) begin
            work  <= {12'h000, load_val};
            cap   <= value_q;
            iter  <= 3'd0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= work_next;
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= DONE;
        end
        DONE: begin
          bcd       <= work[19:8];
          last_conv <= cap;
`ifdef SIGNED_DISPLAY_EN
          neg       <= cap[7];
`endif
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_cnt <= 16'd0;
      digit_idx   <= 2'd0;
    end else if (refresh_cnt == TERM) begin
      refresh_cnt <= 16'd0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 16'd1;
    end
  end

  always_comb begin
    an_next  = 4'b1110;
    seg_next = seg_of(bcd[3:0]);
    case (digit_idx)
      2'd1: begin
        an_next  = 4'b1101;
        seg_next = (bcd[11:4] == 8'h00) ? BLANK : seg_of(bcd[7:4]);
      end
      2'd2: begin
        an_next  = 4'b1011;
        seg_next = (bcd[11:8] == 4'h0) ? BLANK : seg_of(bcd[11:8]);
      end
      2'd3: begin
        an_next  = 4'b0111;
`ifdef SIGNED_DISPLAY_EN
        seg_next = neg ? 7'b0111111 : BLANK;
`else
        seg_next = BLANK;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 4'b1110;
      seg <= 7'b1000000;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_out_display_driver.sv
// tb/tb_out_display_driver.sv - scoreboard bench for out_display_driver (REFRESH_DIV=4)
module tb_out_display_driver;

  localparam int DIV = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  value = 8'h00;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic [11:0] bcd;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic busy_d = 1'b0;

  out_display_driver #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .value(value),
    .seg(seg), .an(an), .busy(busy), .bcd(bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mag_of(input logic [7:0] v);
`ifdef SIGNED_DISPLAY_EN
    return v[7] ? 256 - int'(v) : int'(v);
`else
    return int'(v);
`endif
  endfunction

  function automatic logic [11:0] exp_bcd(input logic [7:0] v);
    int m;
    m = mag_of(v);
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return BLANK;
    endcase
  endfunction

  // Scoreboard: a conversion result is due whenever busy falls outside reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_d <= 1'b0;
    end else begin
      if (busy_d && !busy) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sb_bcd", bcd, exp_q.pop_front());
      end
      busy_d <= busy;
    end
  end

  task automatic apply(input logic [7:0] v);
    value = v;
    exp_q.push_back(exp_bcd(v));
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < max) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, lvl);
  endtask

  task automatic wait_conv(input string tag);
    wait_busy(1'b1, 20, {tag, "_rise"});
    wait_busy(1'b0, 20, {tag, "_fall"});
  endtask

  task automatic check_scan(input logic [7:0] v, input string tag);
    int m;
    int run;
    logic partial;
    logic [3:0] prev;
    logic [6:0] e0, e1, e2, e3;
    m  = mag_of(v);
    e0 = seg_code(m % 10);
    e1 = (m < 10)  ? BLANK : seg_code((m / 10) % 10);
    e2 = (m < 100) ? BLANK : seg_code(m / 100);
`ifdef SIGNED_DISPLAY_EN
    e3 = v[7] ? 7'b0111111 : BLANK;
`else
    e3 = BLANK;
`endif
    prev = an;
    run = 0;
    partial = 1'b1;
    for (int i = 0; i < 6 * DIV; i++) begin
      @(negedge clk);
      check({tag, "_an_onehot"}, $countones(~an), 1);
      case (an)
        4'b1110: check({tag, "_seg_d0"}, seg, e0);
        4'b1101: check({tag, "_seg_d1"}, seg, e1);
        4'b1011: check({tag, "_seg_d2"}, seg, e2);
        4'b0111: check({tag, "_seg_d3"}, seg, e3);
        default: ;
      endcase
      if (an != prev) begin
        if (!partial) check({tag, "_dwell"}, run, DIV);
        check({tag, "_an_order"}, an, {prev[2:0], prev[3]});
        partial = 1'b0;
        prev = an;
        run = 1;
      end else begin
        run++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", an, 4'b1110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_busy", busy, 1'b0);
    check("rst_bcd", bcd, 12'h000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0 -> 173 with edge-exact latency
    apply(8'd173);
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      if (e == 1)  check("lat_e1_busy", busy, 1'b0);
      if (e == 2)  check("lat_e2_busy", busy, 1'b1);
      if (e == 10) check("lat_e10_busy", busy, 1'b1);
      if (e == 10) check("lat_e10_bcd", bcd, 12'h000);
      if (e == 11) check("lat_e11_busy", busy, 1'b0);
      if (e == 11) check("lat_e11_bcd", bcd, 12'h173);
    end
    check_scan(8'd173, "v173");

    apply(8'd5);
    wait_conv("v5");
    check("v5_bcd", bcd, 12'h005);
    check_scan(8'd5, "v5");

    // change during an in-flight conversion
    apply(8'd200);
    wait_busy(1'b1, 20, "v200_rise");
    repeat (3) @(negedge clk);
    apply(8'd9);
    wait_busy(1'b0, 20, "v200_fall");
    check("v200_bcd", bcd, 12'h200);
    wait_conv("v9");
    check("v9_busy", busy, 1'b0);
    check("v9_bcd", bcd, 12'h009);
    check_scan(8'd9, "v9");

    apply(8'd255);
    wait_conv("v255");
    check("v255_bcd", bcd, 12'h255);

    // reset mid-conversion: the aborted value is never expected
    value = 8'd42;
    wait_busy(1'b1, 20, "v42_rise");
    repeat (3) @(negedge clk);
    value = 8'd255;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_an", an, 4'b1110);
    check("arst_seg", seg, 7'b1000000);
    check("arst_busy", busy, 1'b0);
    check("arst_bcd", bcd, 12'h000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(exp_bcd(8'd255));
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      if (e == 2)  check("rel_e2_busy", busy, 1'b1);
      if (e == 10) check("rel_e10_bcd", bcd, 12'h000);
      if (e == 11) check("rel_e11_busy", busy, 1'b0);
      if (e == 11) check("rel_e11_bcd", bcd, 12'h255);
    end
    check_scan(8'd255, "v255");

`ifdef SIGNED_DISPLAY_EN
    apply(8'hFF);
    wait_conv("sFF");
    check("sFF_bcd", bcd, 12'h001);
    check_scan(8'hFF, "sFF");
    apply(8'h80);
    wait_conv("s80");
    check("s80_bcd", bcd, 12'h128);
    check_scan(8'h80, "s80");
    apply(8'h7F);
    wait_conv("s7F");
    check("s7F_bcd", bcd, 12'h127);
    check_scan(8'h7F, "s7F");
`endif

    repeat (3) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
